// File: rtl/font_pkg.sv
// Shared widths, glyph geometry and state/owner encodings for the font fetch path.
package font_pkg;

    localparam int unsigned CODE_W  = 8;
    localparam int unsigned ROW_W   = 3;
    localparam int unsigned FONT_AW = CODE_W + ROW_W;
    localparam int unsigned GLYPH_W = 8;

    typedef enum logic [1:0] {
        M_IDLE,
        M_ADDR,
        M_DATA
    } mem_state_t;

    typedef enum logic {
        OWN_RENDER,
        OWN_HOST
    } owner_t;

endpackage

// File: rtl/glyph_shifter.sv
// One-entry glyph-row hold buffer feeding an 8-bit serialiser, bit 0 leaves first.
module glyph_shifter
    import font_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_capture,
    input  logic [GLYPH_W-1:0] i_row,
    output logic               o_pix,
    output logic               o_pix_valid,
    output logic               o_hold_full
);

    logic [GLYPH_W-1:0] r_shift;
    logic [GLYPH_W-1:0] r_hold;
    logic [3:0]         r_count;
    logic               r_hold_full;
    logic               w_free;

    // Count of 1 means the last pixel is on the wire now, so a reload keeps the stream gap-free.
    assign w_free = (r_count <= 4'd1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift     <= '0;
            r_hold      <= '0;
            r_count     <= '0;
            r_hold_full <= 1'b0;
        end else if (r_hold_full && w_free) begin
            r_shift     <= r_hold;
            r_count     <= 4'(GLYPH_W);
            r_hold_full <= i_capture;
            if (i_capture) begin
                r_hold <= i_row;
            end
        end else if (i_capture && w_free) begin
            r_shift <= i_row;
            r_count <= 4'(GLYPH_W);
        end else begin
            if (i_capture) begin
                r_hold      <= i_row;
                r_hold_full <= 1'b1;
            end
            if (r_count != 4'd0) begin
                r_shift <= r_shift >> 1;
                r_count <= r_count - 4'd1;
            end
        end
    end

    assign o_pix_valid = (r_count != 4'd0);
    assign o_pix       = o_pix_valid & r_shift[0];
    assign o_hold_full = r_hold_full;

endmodule

// File: rtl/font_fetch_ctrl.sv
// Font ROM read sequencer: renderer glyph-row fetches and host reads share one
// ROM port behind a starvation-bounded arbiter; render rows are serialised to pixels.
module font_fetch_ctrl
    import font_pkg::*;
#(
    parameter int unsigned HOST_WAIT = 16
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               char_valid_i,
    input  logic [CODE_W-1:0]  char_code_i,
    input  logic [ROW_W-1:0]   row_i,
    output logic               char_ready_o,
    output logic [FONT_AW-1:0] font_addr_o,
    input  logic [GLYPH_W-1:0] font_dout_i,
    output logic               pix_o,
    output logic               pix_valid_o,
    input  logic               host_req_i,
    input  logic [FONT_AW-1:0] host_addr_i,
    output logic               host_gnt_o,
    output logic [GLYPH_W-1:0] host_rdata_o,
    output logic               host_rvalid_o
);

    localparam int unsigned WAIT_W = $clog2(HOST_WAIT + 1);

    mem_state_t         r_state;
    mem_state_t         w_next;
    owner_t             r_owner;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [FONT_AW-1:0] r_font_addr;
    logic [GLYPH_W-1:0] r_host_rdata;
    logic               r_host_rvalid;
    logic               w_starve;
    logic               w_hold_full;
    logic               w_ready;
    logic               w_gnt;
    logic               w_accept;
    logic               w_capture;
    logic               w_host_data;

    assign w_starve    = (r_wait_cnt >= WAIT_W'(HOST_WAIT));
    assign w_accept    = char_valid_i & w_ready;
    assign w_capture   = (r_state == M_DATA) && (r_owner == OWN_RENDER);
    assign w_host_data = (r_state == M_DATA) && (r_owner == OWN_HOST);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= M_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Handshakes are gated by rstn_i so they read 0 for the whole reset window.
    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_gnt   = 1'b0;
        case (r_state)
            M_IDLE: begin
                w_ready = rstn_i & ~w_hold_full & ~(host_req_i & w_starve);
                w_gnt   = rstn_i & host_req_i & (w_starve | ~(char_valid_i & ~w_hold_full));
                if ((char_valid_i & w_ready) | w_gnt) begin
                    w_next = M_ADDR;
                end
            end
            M_ADDR:  w_next = M_DATA;
            M_DATA:  w_next = M_IDLE;
            default: w_next = M_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_font_addr   <= '0;
            r_owner       <= OWN_RENDER;
            r_wait_cnt    <= '0;
            r_host_rdata  <= '0;
            r_host_rvalid <= 1'b0;
        end else begin
            if (w_gnt) begin
                r_font_addr <= host_addr_i;
                r_owner     <= OWN_HOST;
            end else if (w_accept) begin
                r_font_addr <= {char_code_i, row_i};
                r_owner     <= OWN_RENDER;
            end
            if (!host_req_i || w_gnt) begin
                r_wait_cnt <= '0;
            end else if (!w_starve) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
            r_host_rvalid <= w_host_data;
            if (w_host_data) begin
                r_host_rdata <= font_dout_i;
            end
        end
    end

    glyph_shifter u_shifter (
        .i_clk       (clk_i),
        .i_rst_n     (rstn_i),
        .i_capture   (w_capture),
        .i_row       (font_dout_i),
        .o_pix       (pix_o),
        .o_pix_valid (pix_valid_o),
        .o_hold_full (w_hold_full)
    );

    assign char_ready_o  = w_ready;
    assign host_gnt_o    = w_gnt;
    assign font_addr_o   = r_font_addr;
    assign host_rdata_o  = r_host_rdata;
    assign host_rvalid_o = r_host_rvalid;

endmodule

// File: tb/tb_font_fetch_ctrl.sv
// Bench for font_fetch_ctrl: directed vector table, multi-cycle corner sequences,
// and randomized traffic scored against a queue-based model of pixels and host reads.
module tb_font_fetch_ctrl;

    localparam int HOST_WAIT = 16;

    logic        clk;
    logic        rstn_i;
    logic        char_valid_i;
    logic [7:0]  char_code_i;
    logic [2:0]  row_i;
    logic        char_ready_o;
    logic [10:0] font_addr_o;
    logic [7:0]  font_dout_i;
    logic        pix_o;
    logic        pix_valid_o;
    logic        host_req_i;
    logic [10:0] host_addr_i;
    logic        host_gnt_o;
    logic [7:0]  host_rdata_o;
    logic        host_rvalid_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    font_fetch_ctrl #(.HOST_WAIT(HOST_WAIT)) dut (
        .clk_i         (clk),
        .rstn_i        (rstn_i),
        .char_valid_i  (char_valid_i),
        .char_code_i   (char_code_i),
        .row_i         (row_i),
        .char_ready_o  (char_ready_o),
        .font_addr_o   (font_addr_o),
        .font_dout_i   (font_dout_i),
        .pix_o         (pix_o),
        .pix_valid_o   (pix_valid_o),
        .host_req_i    (host_req_i),
        .host_addr_i   (host_addr_i),
        .host_gnt_o    (host_gnt_o),
        .host_rdata_o  (host_rdata_o),
        .host_rvalid_o (host_rvalid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Font image contents: an arbitrary but fixed byte per address.
    function automatic logic [7:0] img(input logic [10:0] a);
        logic [15:0] t;
        t = {5'd0, a} * 16'd157 + 16'h03A5;
        return t[7:0] ^ t[15:8] ^ {a[2:0], a[10:6]};
    endfunction

    logic [7:0] rom_q;
    always @(posedge clk) rom_q <= img(font_addr_o);
    assign font_dout_i = rom_q;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Scoreboard: pixels leave in acceptance order; host data returns 3 cycles after grant.
    typedef struct {
        logic [10:0] addr;
        int          due;
    } hexp_t;

    logic  pq[$];
    hexp_t hq[$];
    int    hw = 0;
    logic  m_acc, m_gnt;
    logic [7:0] m_row;

    always @(negedge clk) begin
        if (!rstn_i) begin
            pq.delete();
            hq.delete();
            hw = 0;
        end else begin
            m_acc = char_valid_i & char_ready_o;
            m_gnt = host_req_i & host_gnt_o;
            check("arb_exclusive", 32'(m_acc & m_gnt), 32'd0);
            if (hq.size() > 0 && hq[0].due == cyc) begin
                check("host_rvalid", 32'(host_rvalid_o), 32'd1);
                check("host_rdata", 32'(host_rdata_o), 32'(img(hq[0].addr)));
                void'(hq.pop_front());
            end else begin
                check("host_rvalid_idle", 32'(host_rvalid_o), 32'd0);
            end
            if (pix_valid_o) begin
                if (pq.size() == 0) check("pix_unexpected", 32'(pix_valid_o), 32'd0);
                else check("pix_data", 32'(pix_o), 32'(pq.pop_front()));
            end else begin
                check("pix_idle_zero", 32'(pix_o), 32'd0);
            end
            if (m_acc) begin
                m_row = img({char_code_i, row_i});
                for (int b = 0; b < 8; b++) pq.push_back(m_row[b]);
            end
            if (m_gnt) begin
                check("host_wait_bound", 32'(hw <= HOST_WAIT + 2), 32'd1);
                hq.push_back('{addr: host_addr_i, due: cyc + 3});
                hw = 0;
            end else if (host_req_i) begin
                hw++;
            end else begin
                hw = 0;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_char_ready"}, 32'(char_ready_o), 32'd0);
        check({tag, "_host_gnt"}, 32'(host_gnt_o), 32'd0);
        check({tag, "_pix_valid"}, 32'(pix_valid_o), 32'd0);
        check({tag, "_pix"}, 32'(pix_o), 32'd0);
        check({tag, "_host_rvalid"}, 32'(host_rvalid_o), 32'd0);
        check({tag, "_font_addr"}, 32'(font_addr_o), 32'd0);
        check({tag, "_host_rdata"}, 32'(host_rdata_o), 32'd0);
    endtask

    task automatic do_render(input logic [7:0] code, input logic [2:0] row,
                             input logic [10:0] eaddr, input logic [7:0] edata);
        @(posedge clk); #1;
        char_valid_i = 1'b1; char_code_i = code; row_i = row;
        @(negedge clk); check("render_ready", 32'(char_ready_o), 32'd1);
        @(posedge clk); #1;
        char_valid_i = 1'b0;
        @(negedge clk); check("render_font_addr", 32'(font_addr_o), 32'(eaddr));
        @(negedge clk); check("render_lat_T2", 32'(pix_valid_o), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("render_pix_valid", 32'(pix_valid_o), 32'd1);
            check("render_pix_bit", 32'(pix_o), 32'(edata[i]));
        end
        @(negedge clk);
        check("render_underflow_valid", 32'(pix_valid_o), 32'd0);
        check("render_underflow_pix", 32'(pix_o), 32'd0);
    endtask

    task automatic do_host(input logic [10:0] addr, input logic [7:0] edata);
        @(posedge clk); #1;
        host_req_i = 1'b1; host_addr_i = addr;
        @(negedge clk); check("host_gnt_now", 32'(host_gnt_o), 32'd1);
        @(posedge clk); #1;
        host_req_i = 1'b0;
        @(negedge clk); check("host_rvalid_T1", 32'(host_rvalid_o), 32'd0);
        @(negedge clk); check("host_rvalid_T2", 32'(host_rvalid_o), 32'd0);
        @(negedge clk);
        check("host_rvalid_T3", 32'(host_rvalid_o), 32'd1);
        check("host_rdata_T3", 32'(host_rdata_o), 32'(edata));
        @(negedge clk);
        check("host_rvalid_T4", 32'(host_rvalid_o), 32'd0);
        check("host_rdata_hold", 32'(host_rdata_o), 32'(edata));
    endtask

    typedef struct {
        bit          is_host;
        logic [7:0]  code;
        logic [2:0]  row;
        logic [10:0] exp_addr;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, g, npix, first, gaps, r;
        logic acc, gnt;

        vecs[0] = '{1'b0, 8'h41, 3'd3, 11'h20B, img(11'h20B)};
        vecs[1] = '{1'b0, 8'h00, 3'd0, 11'h000, img(11'h000)};
        vecs[2] = '{1'b0, 8'hFF, 3'd7, 11'h7FF, img(11'h7FF)};
        vecs[3] = '{1'b1, 8'h00, 3'd0, 11'h000, img(11'h000)};
        vecs[4] = '{1'b1, 8'h00, 3'd0, 11'h7FF, img(11'h7FF)};
        vecs[5] = '{1'b1, 8'h00, 3'd0, 11'h20B, img(11'h20B)};
        vecs[6] = '{1'b0, 8'h80, 3'd5, 11'h405, img(11'h405)};

        // Reset with requests asserted: handshakes must stay low.
        rstn_i = 1'b0; char_valid_i = 1'b1; host_req_i = 1'b1;
        char_code_i = 8'h41; row_i = 3'd3; host_addr_i = 11'h123;
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("rst");
        char_valid_i = 1'b0; host_req_i = 1'b0;
        @(posedge clk); #1 rstn_i = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(char_ready_o), 32'd1);
        check("post_rst_pix_valid", 32'(pix_valid_o), 32'd0);

        for (int i = 0; i < 7; i++) begin
            repeat (3) @(posedge clk);
            if (vecs[i].is_host) do_host(vecs[i].exp_addr, vecs[i].exp_data);
            else do_render(vecs[i].code, vecs[i].row, vecs[i].exp_addr, vecs[i].exp_data);
        end

        // Back-to-back stream of one glyph: 64 pixels with no gap.
        repeat (3) @(posedge clk);
        #1 char_valid_i = 1'b1; char_code_i = 8'h41; r = 0; row_i = 3'd0;
        npix = 0; first = -1; gaps = 0;
        for (int c = 0; c < 200 && npix < 64; c++) begin
            @(negedge clk);
            acc = char_valid_i & char_ready_o;
            if (pix_valid_o) begin
                if (first < 0) first = cyc;
                npix++;
            end else if (first >= 0) begin
                gaps++;
            end
            @(posedge clk); #1;
            if (acc) begin
                if (r == 7) char_valid_i = 1'b0;
                else begin r++; row_i = 3'(r); end
            end
        end
        check("stream_pix_count", 32'(npix), 32'd64);
        check("stream_gaps", 32'(gaps), 32'd0);
        @(negedge clk); check("stream_end", 32'(pix_valid_o), 32'd0);

        // Contention: renderer wins, host takes the next idle slot.
        repeat (3) @(posedge clk);
        #1 char_valid_i = 1'b1; char_code_i = 8'h12; row_i = 3'd4;
        host_req_i = 1'b1; host_addr_i = 11'h155;
        @(negedge clk);
        check("cont_ready", 32'(char_ready_o), 32'd1);
        check("cont_gnt", 32'(host_gnt_o), 32'd0);
        t0 = cyc; g = -1;
        @(posedge clk); #1 char_valid_i = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (host_gnt_o) begin g = cyc; break; end
            @(posedge clk); #1;
        end
        check("cont_gnt_slot", 32'(g - t0), 32'd3);
        @(posedge clk); #1 host_req_i = 1'b0;
        repeat (12) @(posedge clk);

        // Starvation bound with the renderer always valid.
        #1 host_req_i = 1'b1; host_addr_i = 11'h3C3;
        char_valid_i = 1'b1; char_code_i = 8'h55; r = 0; row_i = 3'd0;
        g = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (host_gnt_o) begin
                check("starve_ready_low", 32'(char_ready_o), 32'd0);
                g = c;
                break;
            end
            acc = char_valid_i & char_ready_o;
            @(posedge clk); #1;
            if (acc) begin r = (r + 1) % 8; row_i = 3'(r); end
        end
        check("starve_granted", 32'(g >= 0 && g <= HOST_WAIT + 2), 32'd1);
        @(posedge clk); #1 host_req_i = 1'b0; char_valid_i = 1'b0;
        repeat (30) @(posedge clk);

        // Reset while a render fetch is in M_ADDR.
        #1 char_valid_i = 1'b1; char_code_i = 8'h41; row_i = 3'd3;
        @(posedge clk); #1 char_valid_i = 1'b0;
        #2 rstn_i = 1'b0; char_valid_i = 1'b1; host_req_i = 1'b1;
        #1 check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1 char_valid_i = 1'b0; host_req_i = 1'b0; rstn_i = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            check("midrst_no_pix", 32'(pix_valid_o), 32'd0);
            check("midrst_no_rvalid", 32'(host_rvalid_o), 32'd0);
        end
        do_render(8'h41, 3'd3, 11'h20B, img(11'h20B));

        // Randomized traffic; the scoreboard checks every cycle.
        acc = 1'b0; gnt = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (acc || !char_valid_i) begin
                char_valid_i = ($urandom_range(0, 9) < 7);
                char_code_i  = 8'($urandom);
                row_i        = 3'($urandom);
            end
            if (gnt || !host_req_i) begin
                host_req_i  = ($urandom_range(0, 9) < 2);
                host_addr_i = 11'($urandom);
            end
            @(negedge clk);
            acc = char_valid_i & char_ready_o;
            gnt = host_req_i & host_gnt_o;
        end
        @(posedge clk); #1 char_valid_i = 1'b0; host_req_i = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("drain_pixels", 32'(pq.size()), 32'd0);
        check("drain_host", 32'(hq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
